tt_bin_clock_shift_tx: RTL and testbench
========================================

TT_BIN_CLOCK_SHIFT_TX -- requirements
Module: tt_bin_clock_shift_tx

Interface
REQ-001 Parameter SCLK_DIV, default 4, sclk_o half-period in clk_i cycles; legal range 1..255.
REQ-002 clk_i  input  1  single system clock; all logic on rising edge.
REQ-003 reset_i  input  1  asynchronous, active-low reset.
REQ-004 start_i  input  1  request one frame transmission; level sampled each clk_i edge.
REQ-005 hour_i  input  4  binary hours from the time keeper, 0..15 accepted.
REQ-006 minute_i  input  6  binary minutes, 0..63 accepted.
REQ-007 seconds_i  input  6  binary seconds, 0..63 accepted.
REQ-008 sclk_o  output  1  serial shift clock to external shift-register chain; idle low.
REQ-009 sdata_o  output  1  serial data, valid on sclk_o rising edge.
REQ-010 latch_o  output  1  storage-register latch strobe, active high.
REQ-011 busy_o  output  1  frame in progress.
REQ-012 done_o  output  1  one-cycle pulse at frame completion.

Function
REQ-013 States SHALL be IDLE, LOAD, SHIFT, LATCH and DONE.
REQ-014 In IDLE or DONE, start_i=1 SHALL move to LOAD on the next edge; otherwise DONE SHALL return to IDLE after one cycle.
REQ-015 LOAD SHALL last 1 cycle and capture hour_i, minute_i and seconds_i into a snapshot; later input changes SHALL NOT affect the frame.
REQ-016 The snapshot SHALL be converted to BCD: each field becomes a tens digit and a units digit, 4 bits each, with the tens digit = value/10 and the units digit = value mod 10.
REQ-017 Frame SHALL be 24 bits: hours tens, hours units, minutes tens, minutes units, seconds tens, seconds units; each field is sent MSB first.
REQ-018 Out-of-range values SHALL encode arithmetically without clamping: hour 15 gives 1,5; minute 63 gives 6,3.
REQ-019 SHIFT, per bit: sdata_o updated at bit start, then sclk_o low for SCLK_DIV cycles, then high for SCLK_DIV cycles; sdata_o SHALL be stable for the whole bit.
REQ-020 SHIFT SHALL last exactly 48*SCLK_DIV cycles; a 5-bit bit counter SHALL run 0..23 and SHALL NOT wrap inside a frame.
REQ-021 LATCH SHALL hold latch_o=1 for SCLK_DIV cycles, with sclk_o=0.
REQ-022 busy_o SHALL be 1 in LOAD, SHIFT and LATCH only, giving 1+49*SCLK_DIV cycles, i.e. 197 cycles at the default.
REQ-023 done_o SHALL be 1 only in DONE, so busy_o and done_o are never both high.
REQ-024 start_i while busy_o=1 SHALL be ignored, not queued.
REQ-025 start_i held high continuously SHALL produce back-to-back frames, each with a fresh LOAD snapshot.
REQ-026 sdata_o SHALL be 0 outside SHIFT.

Reset
REQ-027 reset_i=0 SHALL immediately force IDLE, with sclk_o, sdata_o, latch_o, busy_o and done_o all 0, and clear the snapshot and counters, including mid-frame.
REQ-028 After reset_i is released, no frame SHALL start without a new start_i sampled in IDLE.

Structure
REQ-029 Package tt_bin_clock_pkg SHALL hold FRAME_BITS=24, the field widths (4/6/6) and the state encoding.
REQ-030 The 0..63 binary-to-two-digit BCD converter SHALL be a sub-module tt_bin_to_bcd, instantiated three times with hour_i zero-extended.
REQ-031 The half-period divider and the bit counter SHALL live inside tt_bin_clock_shift_tx.

Verification
REQ-032 Reset, then start pulse with 12:34:56 -> serial capture 0x123456, latch_o high 4 cycles, done_o 1 cycle, busy_o high 197 cycles.
REQ-033 Start with 15:63:59 -> frame 0x156359.
REQ-034 Change minute_i from 34 to 00 mid-SHIFT after capturing 12:34:56 -> frame still 0x123456.
REQ-035 Second start_i pulse at cycle 50 of the frame -> ignored; exactly one done_o pulse.
REQ-036 reset_i low at bit 10 -> all outputs 0 the same cycle; after release with no start, outputs stay idle for 300 cycles.
REQ-037 SCLK_DIV=1 with start_i held high and 00:00:01 -> back-to-back frames 0x000001, each busy for 50 cycles, separated by a single DONE cycle.

Source files
------------

// File: rtl/tt_bin_clock_pkg.sv
// rtl/tt_bin_clock_pkg.sv - shared widths, frame size and state encoding for the binary clock shift transmitter
package tt_bin_clock_pkg;

  localparam int FRAME_BITS = 24;
  localparam int HOUR_W     = 4;
  localparam int MIN_W      = 6;
  localparam int SEC_W      = 6;
  localparam int BCD_W      = 4;
  localparam int BIT_CNT_W  = 5;
  localparam int DIV_CNT_W  = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_LATCH = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/tt_bin_to_bcd.sv
// rtl/tt_bin_to_bcd.sv - 0..63 binary to two-digit BCD (tens, units)
module tt_bin_to_bcd
  import tt_bin_clock_pkg::*;
(
  input  logic [MIN_W-1:0] bin_i,
  output logic [BCD_W-1:0] tens_o,
  output logic [BCD_W-1:0] units_o
);

  logic [MIN_W-1:0] base;

  // Tens digit by range compare; units digit is what is left above that decade.
  always_comb begin
    tens_o = 4'd0;
    base   = 6'd0;
    if (bin_i >= 6'd60) begin
      tens_o = 4'd6;
      base   = 6'd60;
    end else if (bin_i >= 6'd50) begin
      tens_o = 4'd5;
      base   = 6'd50;
    end else if (bin_i >= 6'd40) begin
      tens_o = 4'd4;
      base   = 6'd40;
    end else if (bin_i >= 6'd30) begin
      tens_o = 4'd3;
      base   = 6'd30;
    end else if (bin_i >= 6'd20) begin
      tens_o = 4'd2;
      base   = 6'd20;
    end else if (bin_i >= 6'd10) begin
      tens_o = 4'd1;
      base   = 6'd10;
    end
    units_o = 4'(bin_i - base);
  end

endmodule

// File: rtl/tt_bin_clock_shift_tx.sv
// rtl/tt_bin_clock_shift_tx.sv - snapshots h:m:s, shifts it out as 24-bit BCD with sclk/latch strobes
module tt_bin_clock_shift_tx
  import tt_bin_clock_pkg::*;
#(
  parameter int unsigned SCLK_DIV = 4
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [HOUR_W-1:0] hour_i,
  input  logic [MIN_W-1:0]  minute_i,
  input  logic [SEC_W-1:0]  seconds_i,
  output logic              sclk_o,
  output logic              sdata_o,
  output logic              latch_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam logic [DIV_CNT_W-1:0] DIV_LAST = DIV_CNT_W'(SCLK_DIV - 1);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(FRAME_BITS - 1);

  state_e                state_q, state_d;
  logic [DIV_CNT_W-1:0]  div_cnt_q, div_cnt_d;
  logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [BIT_CNT_W-1:0]  bit_next;
  logic                  sclk_q, sclk_d;
  logic                  sdata_q, sdata_d;
  logic                  latch_q, latch_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [HOUR_W-1:0]     hour_q, hour_d;
  logic [MIN_W-1:0]      minute_q, minute_d;
  logic [SEC_W-1:0]      seconds_q, seconds_d;

  logic [BCD_W-1:0]      h_tens, h_units, m_tens, m_units, s_tens, s_units;
  logic [FRAME_BITS-1:0] frame;

  tt_bin_to_bcd u_bcd_hour (
    .bin_i   ({2'b00, hour_q}),
    .tens_o  (h_tens),
    .units_o (h_units)
  );

  tt_bin_to_bcd u_bcd_minute (
    .bin_i   (minute_q),
    .tens_o  (m_tens),
    .units_o (m_units)
  );

  tt_bin_to_bcd u_bcd_seconds (
    .bin_i   (seconds_q),
    .tens_o  (s_tens),
    .units_o (s_units)
  );

  // Frame order on the wire: hours, minutes, seconds; tens before units; bit 23 goes first.
  assign frame    = {h_tens, h_units, m_tens, m_units, s_tens, s_units};
  assign bit_next = bit_cnt_q + 5'd1;

  // Next-state and next-output logic; outputs are computed for the state being entered.
  always_comb begin
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    bit_cnt_d = bit_cnt_q;
    sclk_d    = sclk_q;
    sdata_d   = sdata_q;
    latch_d   = latch_q;
    busy_d    = busy_q;
    done_d    = done_q;
    hour_d    = hour_q;
    minute_d  = minute_q;
    seconds_d = seconds_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        done_d = 1'b0;
        if (start_i) begin
          state_d   = ST_LOAD;
          busy_d    = 1'b1;
          hour_d    = hour_i;
          minute_d  = minute_i;
          seconds_d = seconds_i;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        state_d   = ST_SHIFT;
        div_cnt_d = '0;
        bit_cnt_d = '0;
        sclk_d    = 1'b0;
        sdata_d   = frame[LAST_BIT];
      end
      ST_SHIFT: begin
        if (div_cnt_q != DIV_LAST) begin
          div_cnt_d = div_cnt_q + 8'd1;
        end else begin
          div_cnt_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d = 1'b0;
            if (bit_cnt_q == LAST_BIT) begin
              state_d = ST_LATCH;
              sdata_d = 1'b0;
              latch_d = 1'b1;
            end else begin
              bit_cnt_d = bit_next;
              sdata_d   = frame[LAST_BIT - bit_next];
            end
          end
        end
      end
      ST_LATCH: begin
        if (div_cnt_q != DIV_LAST) begin
          div_cnt_d = div_cnt_q + 8'd1;
        end else begin
          div_cnt_d = '0;
          state_d   = ST_DONE;
          latch_d   = 1'b0;
          busy_d    = 1'b0;
          done_d    = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        sclk_d  = 1'b0;
        sdata_d = 1'b0;
        latch_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  // State, counters, snapshot and registered outputs; reset clears everything at once.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q   <= ST_IDLE;
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      sclk_q    <= 1'b0;
      sdata_q   <= 1'b0;
      latch_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hour_q    <= '0;
      minute_q  <= '0;
      seconds_q <= '0;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      sclk_q    <= sclk_d;
      sdata_q   <= sdata_d;
      latch_q   <= latch_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      hour_q    <= hour_d;
      minute_q  <= minute_d;
      seconds_q <= seconds_d;
    end
  end

  assign sclk_o  = sclk_q;
  assign sdata_o = sdata_q;
  assign latch_o = latch_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;

endmodule

// File: tb/tb_tt_bin_clock_shift_tx.sv
// tb/tb_tt_bin_clock_shift_tx.sv - directed bench for tt_bin_clock_shift_tx
module tb_tt_bin_clock_shift_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_a, start_b;
  logic [3:0] hour_a, hour_b;
  logic [5:0] min_a, sec_a, min_b, sec_b;
  logic       sclk_a, sdata_a, latch_a, busy_a, done_a;
  logic       sclk_b, sdata_b, latch_b, busy_b, done_b;

  int errors = 0;
  int checks = 0;

  logic [3:0]  enc_h [4] = '{4'd15, 4'd9, 4'd10, 4'd0};
  logic [5:0]  enc_m [4] = '{6'd63, 6'd59, 6'd60, 6'd0};
  logic [5:0]  enc_s [4] = '{6'd59, 6'd0, 6'd9, 6'd0};
  logic [23:0] enc_x [4] = '{24'h156359, 24'h095900, 24'h106009, 24'h000000};

  always #5 clk = ~clk;

  tt_bin_clock_shift_tx u_dut_a (
    .clk_i     (clk),
    .reset_i   (rst_n),
    .start_i   (start_a),
    .hour_i    (hour_a),
    .minute_i  (min_a),
    .seconds_i (sec_a),
    .sclk_o    (sclk_a),
    .sdata_o   (sdata_a),
    .latch_o   (latch_a),
    .busy_o    (busy_a),
    .done_o    (done_a)
  );

  tt_bin_clock_shift_tx #(.SCLK_DIV(1)) u_dut_b (
    .clk_i     (clk),
    .reset_i   (rst_n),
    .start_i   (start_b),
    .hour_i    (hour_b),
    .minute_i  (min_b),
    .seconds_i (sec_b),
    .sclk_o    (sclk_b),
    .sdata_o   (sdata_b),
    .latch_o   (latch_b),
    .busy_o    (busy_b),
    .done_o    (done_b)
  );

  task automatic kick_a(input logic [3:0] h, input logic [5:0] m, input logic [5:0] s);
    @(negedge clk);
    hour_a  = h;
    min_a   = m;
    sec_a   = s;
    start_a = 1'b1;
  endtask

  task automatic capture_a(input int max_cycles, output logic [23:0] frame, output int nbits,
                           output int busy_cyc, output int latch_cyc, output int done_cyc,
                           output int overlap, output bit timeout);
    logic prev_sclk;
    int   cyc;
    bit   finished;
    frame = '0; nbits = 0; busy_cyc = 0; latch_cyc = 0; done_cyc = 0; overlap = 0;
    timeout = 1'b0; prev_sclk = 1'b0; cyc = 0; finished = 1'b0;
    while (!finished) begin
      @(negedge clk);
      cyc++;
      if (sclk_a && !prev_sclk) begin
        frame = {frame[22:0], sdata_a};
        nbits++;
      end
      prev_sclk = sclk_a;
      if (busy_a) busy_cyc++;
      if (latch_a) latch_cyc++;
      if (done_a) done_cyc++;
      if (busy_a && done_a) overlap++;
      if (done_cyc > 0 && !done_a) finished = 1'b1;
      else if (cyc >= max_cycles) begin
        timeout  = 1'b1;
        finished = 1'b1;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start_a = 1'b0; hour_a = '0; min_a = '0; sec_a = '0;
    start_b = 1'b0; hour_b = '0; min_b = '0; sec_b = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({sclk_a, sdata_a, latch_a, busy_a, done_a} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_outputs_a: got %b want 00000", {sclk_a, sdata_a, latch_a, busy_a, done_a});
    end
    checks++;
    if ({sclk_b, sdata_b, latch_b, busy_b, done_b} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_outputs_b: got %b want 00000", {sclk_b, sdata_b, latch_b, busy_b, done_b});
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (busy_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_autostart: busy=%b want 0", busy_a);
    end
  endtask

  task automatic test_basic;
    logic [23:0] f;
    int nb, bc, lc, dc, ov;
    bit to;
    kick_a(4'd12, 6'd34, 6'd56);
    fork
      capture_a(400, f, nb, bc, lc, dc, ov, to);
      begin @(negedge clk); start_a = 1'b0; end
    join
    checks++;
    if (to) begin errors++; $display("FAIL basic_timeout: no done within 400 cycles"); end
    checks++;
    if (f !== 24'h123456) begin errors++; $display("FAIL basic_frame: got %h want 123456", f); end
    checks++;
    if (nb != 24) begin errors++; $display("FAIL basic_bits: got %0d want 24", nb); end
    checks++;
    if (bc != 197) begin errors++; $display("FAIL basic_busy_cycles: got %0d want 197", bc); end
    checks++;
    if (lc != 4) begin errors++; $display("FAIL basic_latch_cycles: got %0d want 4", lc); end
    checks++;
    if (dc != 1) begin errors++; $display("FAIL basic_done_cycles: got %0d want 1", dc); end
    checks++;
    if (ov != 0) begin errors++; $display("FAIL basic_busy_done_overlap: got %0d want 0", ov); end
  endtask

  task automatic test_encoding;
    logic [23:0] f;
    int nb, bc, lc, dc, ov;
    bit to;
    for (int i = 0; i < 4; i++) begin
      kick_a(enc_h[i], enc_m[i], enc_s[i]);
      fork
        capture_a(400, f, nb, bc, lc, dc, ov, to);
        begin @(negedge clk); start_a = 1'b0; end
      join
      checks++;
      if (to || f !== enc_x[i]) begin
        errors++;
        $display("FAIL encoding_%0d: got %h timeout=%0d want %h", i, f, to, enc_x[i]);
      end
    end
  endtask

  task automatic test_snapshot;
    logic [23:0] f;
    int nb, bc, lc, dc, ov;
    bit to;
    kick_a(4'd12, 6'd34, 6'd56);
    fork
      capture_a(400, f, nb, bc, lc, dc, ov, to);
      begin
        @(negedge clk); start_a = 1'b0;
        repeat (60) @(negedge clk);
        min_a = 6'd0; hour_a = 4'd3; sec_a = 6'd7;
      end
    join
    checks++;
    if (to || f !== 24'h123456) begin
      errors++;
      $display("FAIL snapshot_frame: got %h timeout=%0d want 123456", f, to);
    end
  endtask

  task automatic test_ignore_start;
    logic [23:0] f;
    int nb, bc, lc, dc, ov, extra;
    bit to;
    kick_a(4'd12, 6'd34, 6'd56);
    fork
      capture_a(400, f, nb, bc, lc, dc, ov, to);
      begin
        @(negedge clk); start_a = 1'b0;
        repeat (48) @(negedge clk);
        start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
      end
    join
    checks++;
    if (to || dc != 1) begin errors++; $display("FAIL ignore_done_count: got %0d want 1", dc); end
    checks++;
    if (bc != 197) begin errors++; $display("FAIL ignore_busy_cycles: got %0d want 197", bc); end
    extra = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy_a || done_a) extra++;
    end
    checks++;
    if (extra != 0) begin errors++; $display("FAIL ignore_no_queued_frame: got %0d active cycles want 0", extra); end
  endtask

  task automatic test_reset_mid;
    int rises, cyc, bad;
    logic prev;
    kick_a(4'd12, 6'd34, 6'd56);
    @(negedge clk); start_a = 1'b0;
    rises = 0; cyc = 0; prev = 1'b0;
    while (rises < 11 && cyc < 600) begin
      @(negedge clk);
      cyc++;
      if (sclk_a && !prev) rises++;
      prev = sclk_a;
    end
    checks++;
    if (rises != 11) begin errors++; $display("FAIL resetmid_reach_bit10: got %0d rises want 11", rises); end
    checks++;
    if (busy_a !== 1'b1) begin errors++; $display("FAIL resetmid_in_flight: busy=%b want 1", busy_a); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({sclk_a, sdata_a, latch_a, busy_a, done_a} !== 5'b00000) begin
      errors++;
      $display("FAIL resetmid_immediate: got %b want 00000", {sclk_a, sdata_a, latch_a, busy_a, done_a});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (300) begin
      @(negedge clk);
      if ({sclk_a, sdata_a, latch_a, busy_a, done_a} !== 5'b00000) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL resetmid_stays_idle: got %0d active cycles want 0", bad); end
  endtask

  task automatic test_back_to_back;
    int          run_len [3];
    logic [23:0] run_frame [3];
    int          runs, cur_len, gap_cnt, gap_len, cyc;
    logic [23:0] cur;
    logic        prev_busy, prev_sclk;
    bit          gap_done_seen;
    run_len = '{0, 0, 0};
    run_frame = '{24'h0, 24'h0, 24'h0};
    runs = 0; cur_len = 0; gap_cnt = 0; gap_len = -1; cyc = 0; cur = '0;
    prev_busy = 1'b0; prev_sclk = 1'b0; gap_done_seen = 1'b0;
    @(negedge clk);
    hour_b = 4'd0; min_b = 6'd0; sec_b = 6'd1; start_b = 1'b1;
    while (runs < 3 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (busy_b) begin
        if (!prev_busy) begin
          cur_len = 0;
          cur = '0;
          if (runs == 1) gap_len = gap_cnt;
        end
        cur_len++;
        if (sclk_b && !prev_sclk) cur = {cur[22:0], sdata_b};
      end else begin
        if (prev_busy) begin
          run_len[runs] = cur_len;
          run_frame[runs] = cur;
          runs++;
          gap_cnt = 0;
        end
        gap_cnt++;
        if (done_b && runs == 1) gap_done_seen = 1'b1;
      end
      prev_busy = busy_b;
      prev_sclk = sclk_b;
    end
    start_b = 1'b0;
    checks++;
    if (runs != 3) begin errors++; $display("FAIL b2b_run_count: got %0d want 3", runs); end
    checks++;
    if (run_frame[0] !== 24'h000001 || run_frame[1] !== 24'h000001) begin
      errors++;
      $display("FAIL b2b_frames: got %h %h want 000001 000001", run_frame[0], run_frame[1]);
    end
    checks++;
    if (run_len[0] != 50 || run_len[1] != 50) begin
      errors++;
      $display("FAIL b2b_busy_len: got %0d %0d want 50 50", run_len[0], run_len[1]);
    end
    checks++;
    if (gap_len != 1 || !gap_done_seen) begin
      errors++;
      $display("FAIL b2b_gap: got len=%0d done=%0d want len=1 done=1", gap_len, gap_done_seen);
    end
    repeat (60) @(negedge clk);
  endtask

  initial begin
    #600000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_encoding();
    test_snapshot();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
